// File: rtl/aes_encrypt_seq_pkg.sv
// Shared definitions for the iterative AES encryptor: FSM encoding, round
// counts per key size, and the AES round primitives (S-box, SubBytes,
// ShiftRows, MixColumns, AddRoundKey, key-schedule word helpers).
// Byte order: byte 0 of a block is bits [127:120]; column c holds bytes 4c..4c+3.
package aes_encrypt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // Round counter width; holds round indices up to 14 without wrapping.
  localparam int RND_W = 4;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] rk);
    return s ^ rk;
  endfunction

  // One full middle round.
  function automatic logic [127:0] encrypt_round(input logic [127:0] s,
                                                 input logic [127:0] rk);
    return add_round_key(mix_columns(shift_rows(sub_bytes(s))), rk);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round_key_select.sv
// Picks round key rnd_i out of the packed key schedule (round 0 in the MSBs).
module aes_round_key_select
  import aes_encrypt_seq_pkg::*;
#(
  parameter int Nr = 10
) (
  input  logic [128*(Nr+1)-1:0] fullkeys_i,
  input  logic [RND_W-1:0]      rnd_i,
  output logic [127:0]          round_key_o
);

  // Wide one-hot style mux over the Nr+1 round keys.
  always_comb begin
    round_key_o = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (rnd_i == RND_W'(r)) round_key_o = fullkeys_i[128*(Nr+1) - 1 - 128*r -: 128];
    end
  end

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES encryptor: one round per clock through a single round
// datapath, key schedule expanded combinationally from the latched key.
// Accept edge -> Nr-1 middle rounds -> final round -> DONE until out_ready.
// Optional build macro AES_ENCRYPT_SEQ_ABORT_EN adds an abort input that
// discards the in-flight block. Parameters must satisfy N = 32*Nk, Nr = Nk+6.
module aes_encrypt_seq
  import aes_encrypt_seq_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
`ifdef AES_ENCRYPT_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int NW  = 4 * (Nr + 1);
  localparam int FKW = 128 * (Nr + 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(Nr - 1);

  aes_fsm_e         fsm_q, fsm_d;
  logic [127:0]     blk_q, blk_d;
  logic [N-1:0]     key_q, key_d;
  logic [RND_W-1:0] rnd_q, rnd_d;

  logic [31:0]      kx_w [NW];
  logic [31:0]      kx_temp;
  logic [7:0]       kx_rcon;
  logic [FKW-1:0]   fullkeys;
  logic [127:0]     round_key;

  // State, block, key and round-counter registers.
  // NOTE: the block and key registers are reset too, because out must read 0
  // after reset and a discarded key must not linger in the key register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      blk_q <= '0;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      key_q <= key_d;
      rnd_q <= rnd_d;
    end
  end

  // Next FSM state.
  always_comb begin
    // NOTE: default first so no path leaves fsm_d unassigned (no latch).
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE:  if (in_valid) fsm_d = ST_ROUND;
      ST_ROUND: if (rnd_q == RND_LAST) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_DONE;
      ST_DONE:  if (out_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
`ifdef AES_ENCRYPT_SEQ_ABORT_EN
    if (abort && fsm_q != ST_IDLE) fsm_d = ST_IDLE;
`endif
  end

  // Key schedule of the latched key, packed round 0 first (MSBs).
  always_comb begin
    kx_w     = '{default: '0};
    kx_rcon  = 8'h01;
    kx_temp  = '0;
    fullkeys = '0;
    for (int i = 0; i < Nk; i++) kx_w[i] = key_q[N - 1 - 32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      kx_temp = kx_w[i-1];
      if (i % Nk == 0) begin
        kx_temp = sub_word(rot_word(kx_temp)) ^ {kx_rcon, 24'h0};
        kx_rcon = xtime(kx_rcon);
      end else if (Nk > 6 && i % Nk == 4) begin
        kx_temp = sub_word(kx_temp);
      end
      kx_w[i] = kx_w[i-Nk] ^ kx_temp;
    end
    for (int i = 0; i < NW; i++) fullkeys[FKW - 1 - 32*i -: 32] = kx_w[i];
  end

  // rnd_q already equals Nr when the FSM sits in FINAL.
  aes_round_key_select #(.Nr(Nr)) u_rk_sel (
    .fullkeys_i  (fullkeys),
    .rnd_i       (rnd_q),
    .round_key_o (round_key)
  );

  // Datapath next values: initial whitening, middle rounds, final round.
  always_comb begin
    blk_d = blk_q;
    key_d = key_q;
    rnd_d = rnd_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_d = key;
          blk_d = add_round_key(in, key[N-1 -: 128]);
          rnd_d = RND_W'(1);
        end
      end
      ST_ROUND: begin
        blk_d = encrypt_round(blk_q, round_key);
        rnd_d = rnd_q + RND_W'(1);
      end
      ST_FINAL: blk_d = add_round_key(shift_rows(sub_bytes(blk_q)), round_key);
      default:  ;
    endcase
`ifdef AES_ENCRYPT_SEQ_ABORT_EN
    if (abort && fsm_q != ST_IDLE) begin
      blk_d = '0;
      key_d = '0;
      rnd_d = '0;
    end
`endif
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out = blk_q;

endmodule

// File: tb/tb_aes_encrypt_seq.sv
// Bench for aes_encrypt_seq: AES-128 instance driven through known-answer
// vectors, backpressure, back-to-back and reset cases; a second AES-256
// instance for the FIPS-197 C.3 vector. Ciphertexts are compared through a
// scoreboard queue filled on accept and drained on the output handshake.
module tb_aes_encrypt_seq;
  import aes_encrypt_seq_pkg::*;

  localparam int NR = NR_AES128;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_blk, key_blk, out_blk;
  logic         abort = 1'b0;

  logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [127:0] in_blk2, out_blk2;
  logic [255:0] key2;

  aes_encrypt_seq #(.N(128), .Nr(NR_AES128), .Nk(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_blk),
    .key       (key_blk),
`ifdef AES_ENCRYPT_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_blk),
    .busy      (busy)
  );

  aes_encrypt_seq #(.N(256), .Nr(NR_AES256), .Nk(8)) u_dut256 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in        (in_blk2),
    .key       (key2),
`ifdef AES_ENCRYPT_SEQ_ABORT_EN
    .abort     (1'b0),
`endif
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out       (out_blk2),
    .busy      (busy2)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_hs = 0;
  int           last_acc_edge = 0;
  logic [127:0] cur_exp = '0;
  logic [127:0] sb[$];
  vec_t         vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_blk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on the output handshake.
  // Edge numbers are recorded as the edge that completes the transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_valid && in_ready) begin
          sb.push_back(cur_exp);
          n_acc++;
          last_acc_edge = cyc + 1;
        end
        if (out_valid && out_ready && !abort) begin
          n_hs++;
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: ciphertext %h with no pending request", out_blk);
          end else begin
            check_blk("sb_ct", out_blk, sb.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_out(input string name, output int per);
    per = 0;
    while (!out_valid && per < 60) begin
      tick();
      per++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: out_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    check_int("drain", sb.size(), 0);
  endtask

  // One block with out_ready high: out_valid must appear in the (Nr+1)th
  // clock period after the accept edge, with in_ready low until the handshake.
  task automatic run_latency(input vec_t v);
    int per;
    bit ready_seen = 1'b0;
    key_blk = v.key; in_blk = v.pt; cur_exp = v.ct;
    in_valid = 1'b1; out_ready = 1'b1;
    check_bit("lat_idle_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    per = 1;
    while (!out_valid && per < 40) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      per++;
    end
    check_int("lat_period", per, NR + 1);
    check_bit("lat_ready_low_run", ready_seen, 1'b0);
    check_bit("lat_ready_low_done", in_ready, 1'b0);
    check_bit("lat_busy_done", busy, 1'b1);
    check_blk("lat_ct", out_blk, v.ct);
    tick();
    check_bit("lat_ready_after_hs", in_ready, 1'b1);
    check_bit("lat_valid_after_hs", out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int per, acc, prev, hs_edge, acc_before, t;
    bit seen;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                128'hf5d3d58503b9699de785895a96fdbaaf};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                128'h43b1cd7f598ece23881b00e3ed030688};

    in_valid = 1'b0; out_ready = 1'b0; in_blk = '0; key_blk = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; in_blk2 = '0; key2 = '0;
    rst = 1'b1;
    repeat (2) tick();
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_blk("rst_out", out_blk, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1 with latency and in_ready timing.
    run_latency(vecs[0]);

    // Back-to-back: in_valid held high, accepts every Nr+2 edges.
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      key_blk = vecs[i].key; in_blk = vecs[i].pt; cur_exp = vecs[i].ct;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      check_bit("b2b_ready_seen", in_ready, 1'b1);
      tick();
      acc = cyc;
      if (i > 0) check_int("b2b_spacing", acc - prev, NR + 2);
      prev = acc;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: ciphertext held, no accept while DONE.
    out_ready = 1'b0;
    key_blk = vecs[0].key; in_blk = vecs[0].pt; cur_exp = vecs[0].ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("bp_wait", per);
    acc_before = n_acc;
    for (int i = 0; i < 20; i++) begin
      check_blk("bp_out_hold", out_blk, vecs[0].ct);
      check_bit("bp_valid_hold", out_valid, 1'b1);
      key_blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_blk  = {$urandom(), $urandom(), $urandom(), $urandom()};
      cur_exp = '1;
      in_valid = i[0];
      tick();
    end
    check_int("bp_no_accept", n_acc, acc_before);
    key_blk = vecs[2].key; in_blk = vecs[2].pt; cur_exp = vecs[2].ct;
    in_valid = 1'b1; out_ready = 1'b1;
    hs_edge = cyc + 1;
    tick();
    check_bit("bp_ready_after_hs", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_int("bp_accept_edge", last_acc_edge - hs_edge, 1);
    drain();

    // Reset between edges in the middle of the rounds.
    key_blk = vecs[0].key; in_blk = vecs[0].pt; cur_exp = vecs[0].ct;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_bit("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("mid_rst_out_valid", out_valid, 1'b0);
    check_bit("mid_rst_in_ready", in_ready, 1'b1);
    check_bit("mid_rst_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_latency(vecs[0]);

    // Reset while DONE: out_valid drops without a clock edge.
    out_ready = 1'b0;
    key_blk = vecs[1].key; in_blk = vecs[1].pt; cur_exp = vecs[1].ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("done_rst_wait", per);
    #2 rst = 1'b1;
    #1;
    check_bit("done_rst_out_valid", out_valid, 1'b0);
    check_blk("done_rst_out", out_blk, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // AES-256, FIPS-197 C.3.
    key2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    in_blk2 = 128'h00112233445566778899aabbccddeeff;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    per = 1;
    while (!out_valid2 && per < 40) begin
      tick();
      per++;
    end
    check_int("aes256_period", per, NR_AES256 + 1);
    check_blk("aes256_ct", out_blk2, 128'h8ea2b7ca516745bfeafc49904b496089);
    tick();

`ifdef AES_ENCRYPT_SEQ_ABORT_EN
    // Abort in the middle of the rounds.
    out_ready = 1'b1;
    key_blk = vecs[0].key; in_blk = vecs[0].pt; cur_exp = vecs[0].ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_bit("abort_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check_bit("abort_no_out_valid", seen, 1'b0);

    // Abort together with out_ready while DONE.
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("abort_done_wait", per);
    acc_before = n_hs;
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    check_bit("abort_done_valid", out_valid, 1'b0);
    check_blk("abort_done_cleared", out_blk, '0);
    check_int("abort_done_no_hs", n_hs, acc_before);
`endif

    check_int("sb_empty_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
